// File: rtl/irq_exception_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : irq_exception_ctrl_if
//  Description : Bundle of request/response signals between the ID-stage
//                pipeline logic (master) and the interrupt/exception
//                controller (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface irq_exception_ctrl_if #(
    parameter int N_IRQ = 4,
    parameter int ID_W  = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
);
    // Pipeline -> controller
    logic [N_IRQ-1:0] irq_in;
    logic             mask_wr;
    logic [N_IRQ-1:0] mask_wdata;
    logic             irq_clr;
    logic [ID_W-1:0]  irq_clr_id;
    logic             ill_op;
    logic [31:0]      id_pc;
    logic             kernel;
    logic             stall;
    logic             eret;

    // Controller -> pipeline
    logic             trap_take;
    logic [1:0]       trap_kind;
    logic [31:0]      trap_vector;
    logic [31:0]      epc;
    logic [ID_W-1:0]  irq_id;
    logic [N_IRQ-1:0] irq_pending;
    logic             busy;
    logic [15:0]      trap_cnt;

    modport master (
        output irq_in, mask_wr, mask_wdata, irq_clr, irq_clr_id,
               ill_op, id_pc, kernel, stall, eret,
        input  trap_take, trap_kind, trap_vector, epc, irq_id,
               irq_pending, busy, trap_cnt
    );

    modport slave (
        input  irq_in, mask_wr, mask_wdata, irq_clr, irq_clr_id,
               ill_op, id_pc, kernel, stall, eret,
        output trap_take, trap_kind, trap_vector, epc, irq_id,
               irq_pending, busy, trap_cnt
    );
endinterface
`default_nettype wire

// File: rtl/irq_exception_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : irq_exception_ctrl
//  Description : Multi-source maskable interrupt controller arbitrated
//                against the decoder's illegal-instruction flag. Issues a
//                combinational one-cycle trap request, captures EPC and
//                tracks handler occupancy until ERET.
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_exception_ctrl #(
    parameter int               N_IRQ     = 4,
    parameter logic [N_IRQ-1:0] IRQ_EDGE  = {N_IRQ{1'b1}},
    parameter logic [N_IRQ-1:0] MASK_INIT = {N_IRQ{1'b1}},
    parameter logic [31:0]      IRQ_VEC   = 32'h8000_0004,
    parameter logic [31:0]      EXC_VEC   = 32'h8000_0008
) (
    input  wire logic              clk,
    input  wire logic              reset,
    irq_exception_ctrl_if.slave    bus
);

    localparam int         ID_W      = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
    localparam logic [1:0] KIND_NONE = 2'b00;
    localparam logic [1:0] KIND_IRQ  = 2'b01;
    localparam logic [1:0] KIND_EXC  = 2'b10;

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_HANDLER = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [N_IRQ-1:0] pend_q, pend_d;
    logic [N_IRQ-1:0] prev_q;
    logic [N_IRQ-1:0] mask_q;
    logic [31:0]      epc_q, epc_d;
    logic [15:0]      cnt_q, cnt_d;

    logic [N_IRQ-1:0] active;
    logic [ID_W-1:0]  irq_id_w;
    logic             take_w;
    logic [1:0]       kind_w;
    logic [31:0]      vector_w;

    // Per-source pending next-state: edge sources latch a rising edge and
    // hold it until cleared (a new edge beats a same-cycle clear); level
    // sources simply follow the input one cycle late.
    for (genvar i = 0; i < N_IRQ; i++) begin : g_src
        if (IRQ_EDGE[i]) begin : g_edge
            logic rise, clr_hit;
            assign rise    = bus.irq_in[i] & ~prev_q[i];
            assign clr_hit = bus.irq_clr && (bus.irq_clr_id == ID_W'(i));
            assign pend_d[i] = rise ? 1'b1 : (clr_hit ? 1'b0 : pend_q[i]);
        end else begin : g_level
            assign pend_d[i] = bus.irq_in[i];
        end
    end

    assign active = pend_q & mask_q;

    // Lowest enabled pending index wins; zero when nothing is active.
    always_comb begin
        irq_id_w = '0;
        for (int k = N_IRQ - 1; k >= 0; k--) begin
            if (active[k]) begin
                irq_id_w = ID_W'(k);
            end
        end
    end

    // Source history, pending and mask registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= '0;
            pend_q <= '0;
            mask_q <= MASK_INIT;
        end else begin
            prev_q <= bus.irq_in;
            pend_q <= pend_d;
            if (bus.mask_wr) begin
                mask_q <= bus.mask_wdata;
            end
        end
    end

    // FSM state, EPC and trap counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            epc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            epc_q   <= epc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Trap arbitration and handler tracking. Interrupts outrank an illegal
    // op in the same cycle; an interrupted instruction re-executes so EPC
    // is its own PC, while a faulting one resumes at the next instruction.
    always_comb begin
        state_d  = state_q;
        epc_d    = epc_q;
        cnt_d    = cnt_q;
        take_w   = 1'b0;
        kind_w   = KIND_NONE;
        vector_w = '0;
        case (state_q)
            S_IDLE: begin
                if (!bus.kernel && !bus.stall) begin
                    if (|active) begin
                        take_w   = 1'b1;
                        kind_w   = KIND_IRQ;
                        vector_w = IRQ_VEC;
                        epc_d    = bus.id_pc;
                    end else if (bus.ill_op) begin
                        take_w   = 1'b1;
                        kind_w   = KIND_EXC;
                        vector_w = EXC_VEC;
                        epc_d    = bus.id_pc + 32'd4;
                    end
                end
                if (take_w) begin
                    state_d = S_HANDLER;
                    if (cnt_q != 16'hFFFF) begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            S_HANDLER: begin
                if (bus.eret) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.trap_take   = take_w;
    assign bus.trap_kind   = kind_w;
    assign bus.trap_vector = vector_w;
    assign bus.epc         = epc_q;
    assign bus.irq_id      = irq_id_w;
    assign bus.irq_pending = pend_q;
    assign bus.busy        = (state_q == S_HANDLER);
    assign bus.trap_cnt    = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_exception_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_irq_exception_ctrl
//  Description : Directed plus randomized bench for irq_exception_ctrl with a
//                cycle-level behavioural reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_exception_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    irq_exception_ctrl_if #(.N_IRQ(4)) bus ();

    irq_exception_ctrl #(.N_IRQ(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit [3:0]    m_pend, m_prev, m_mask;
    bit          m_hand;
    logic [31:0] m_epc;
    int          m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = '0; m_prev = '0; m_mask = 4'hF;
        m_hand = 0; m_epc = '0; m_cnt = 0;
    endtask

    function automatic int first_set(input bit [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    // One clock cycle: drive inputs after the falling edge, check every
    // output against the model, then advance the model past the next edge.
    task automatic step(input bit [3:0] irq, input bit mwr, input bit [3:0] mw,
                        input bit clr, input bit [1:0] cid, input bit ill,
                        input logic [31:0] pc, input bit kern, input bit stl,
                        input bit er);
        bit [3:0]    act;
        bit          take, is_irq;
        logic [31:0] vec;
        @(negedge clk);
        bus.irq_in = irq; bus.mask_wr = mwr; bus.mask_wdata = mw;
        bus.irq_clr = clr; bus.irq_clr_id = cid; bus.ill_op = ill;
        bus.id_pc = pc; bus.kernel = kern; bus.stall = stl; bus.eret = er;
        #1;
        act    = m_pend & m_mask;
        is_irq = (act != 0);
        take   = !m_hand && !kern && !stl && (is_irq || ill);
        vec    = !take ? 32'h0 : (is_irq ? 32'h8000_0004 : 32'h8000_0008);
        chk("trap_take",   {31'b0, bus.trap_take}, {31'b0, take});
        chk("trap_kind",   {30'b0, bus.trap_kind}, !take ? 32'd0 : (is_irq ? 32'd1 : 32'd2));
        chk("trap_vector", bus.trap_vector, vec);
        chk("irq_id",      {30'b0, bus.irq_id}, first_set(act));
        chk("irq_pending", {28'b0, bus.irq_pending}, {28'b0, m_pend});
        chk("busy",        {31'b0, bus.busy}, {31'b0, m_hand});
        chk("epc",         bus.epc, m_epc);
        chk("trap_cnt",    {16'b0, bus.trap_cnt}, m_cnt);
        // Model update for the coming rising edge
        for (int i = 0; i < 4; i++) begin
            if (irq[i] && !m_prev[i])      m_pend[i] = 1'b1;
            else if (clr && cid == i)      m_pend[i] = 1'b0;
        end
        m_prev = irq;
        if (mwr) m_mask = mw;
        if (take) begin
            m_hand = 1;
            m_epc  = is_irq ? pc : pc + 32'd4;
            m_cnt  = (m_cnt < 65535) ? m_cnt + 1 : 65535;
        end else if (m_hand && er) begin
            m_hand = 0;
        end
    endtask

    // Convenience wrappers
    task automatic idle(input logic [31:0] pc);
        step(4'h0, 0, 4'h0, 0, 2'd0, 0, pc, 0, 0, 0);
    endtask

    task automatic clr_eret(input bit [1:0] id);
        step(4'h0, 0, 4'h0, 1, id, 0, 32'h0040_0100, 0, 0, 0);
        step(4'h0, 0, 4'h0, 0, 2'd0, 0, 32'h0040_0100, 0, 0, 1);
    endtask

    initial begin
        bus.irq_in = '0; bus.mask_wr = 0; bus.mask_wdata = '0; bus.irq_clr = 0;
        bus.irq_clr_id = '0; bus.ill_op = 0; bus.id_pc = '0; bus.kernel = 0;
        bus.stall = 0; bus.eret = 0;
        reset = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy",    {31'b0, bus.busy}, 32'd0);
        chk("rst_pending", {28'b0, bus.irq_pending}, 32'd0);
        chk("rst_take",    {31'b0, bus.trap_take}, 32'd0);
        chk("rst_vector",  bus.trap_vector, 32'd0);
        chk("rst_cnt",     {16'b0, bus.trap_cnt}, 32'd0);
        chk("rst_epc",     bus.epc, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Edge on source 2: pending and trap one cycle later
        step(4'b0100, 0, 4'h0, 0, 2'd0, 0, 32'h0040_0010, 0, 0, 0);
        step(4'b0000, 0, 4'h0, 0, 2'd0, 0, 32'h0040_0010, 0, 0, 0);
        chk("d1_pending", {28'b0, bus.irq_pending}, 32'h4);
        chk("d1_take",    {31'b0, bus.trap_take}, 32'd1);
        chk("d1_kind",    {30'b0, bus.trap_kind}, 32'd1);
        chk("d1_vector",  bus.trap_vector, 32'h8000_0004);
        chk("d1_id",      {30'b0, bus.irq_id}, 32'd2);
        idle(32'h0040_0014);
        chk("d1_busy",    {31'b0, bus.busy}, 32'd1);
        chk("d1_epc",     bus.epc, 32'h0040_0010);
        clr_eret(2'd2);
        idle(32'h0040_0020);

        // Simultaneous edges 1 and 3, illegal op presented once pending
        step(4'b1010, 0, 4'h0, 0, 2'd0, 0, 32'h0040_0030, 0, 0, 0);
        step(4'b0000, 0, 4'h0, 0, 2'd0, 1, 32'h0040_0030, 0, 0, 0);
        chk("d2_kind", {30'b0, bus.trap_kind}, 32'd1);
        chk("d2_id",   {30'b0, bus.irq_id}, 32'd1);
        clr_eret(2'd1);
        step(4'h0, 0, 4'h0, 0, 2'd0, 0, 32'h0040_0040, 0, 0, 0);
        chk("d2_retake_id", {30'b0, bus.irq_id}, 32'd3);
        clr_eret(2'd3);

        // Illegal op at the top of the address space: EPC wraps to zero
        step(4'h0, 0, 4'h0, 0, 2'd0, 1, 32'hFFFF_FFFC, 0, 0, 0);
        chk("d3_kind",   {30'b0, bus.trap_kind}, 32'd2);
        chk("d3_vector", bus.trap_vector, 32'h8000_0008);
        idle(32'h0);
        chk("d3_epc", bus.epc, 32'h0);
        step(4'h0, 0, 4'h0, 0, 2'd0, 0, 32'h0, 0, 0, 1);

        // Masked source stays pending; unmasking traps one cycle after write
        step(4'h0, 1, 4'b1011, 0, 2'd0, 0, 32'h0040_0050, 0, 0, 0);
        step(4'b0100, 0, 4'h0, 0, 2'd0, 0, 32'h0040_0050, 0, 0, 0);
        step(4'b0000, 1, 4'b1111, 0, 2'd0, 0, 32'h0040_0054, 0, 0, 0);
        chk("d4_pending", {28'b0, bus.irq_pending}, 32'h4);
        chk("d4_notake",  {31'b0, bus.trap_take}, 32'd0);
        idle(32'h0040_0058);
        chk("d4_take", {31'b0, bus.trap_take}, 32'd1);

        // In handler: new edges accumulate, set beats clear, eret re-arms
        step(4'b0001, 0, 4'h0, 1, 2'd2, 0, 32'h0040_0060, 0, 0, 0);
        chk("d5_notake", {31'b0, bus.trap_take}, 32'd0);
        step(4'b0000, 0, 4'h0, 0, 2'd0, 0, 32'h0040_0060, 0, 0, 0);
        step(4'b0001, 0, 4'h0, 1, 2'd0, 0, 32'h0040_0060, 0, 0, 0);
        step(4'b0001, 0, 4'h0, 0, 2'd0, 0, 32'h0040_0060, 0, 0, 1);
        chk("d5_pend0", {28'b0, bus.irq_pending}, 32'h1);
        idle(32'h0040_0064);
        chk("d5_take_after_eret", {31'b0, bus.trap_take}, 32'd1);
        clr_eret(2'd0);

        // Blocking by kernel and stall, then reset inside the handler
        step(4'b1000, 0, 4'h0, 0, 2'd0, 0, 32'h0040_0070, 0, 0, 0);
        step(4'b0000, 0, 4'h0, 0, 2'd0, 1, 32'h8000_0100, 1, 0, 0);
        chk("d6_kernel", {31'b0, bus.trap_take}, 32'd0);
        step(4'b0000, 0, 4'h0, 0, 2'd0, 1, 32'h0040_0070, 0, 1, 0);
        chk("d6_stall", {31'b0, bus.trap_take}, 32'd0);
        idle(32'h0040_0070);
        idle(32'h0040_0074);
        reset = 1'b1;
        #1;
        chk("d6_rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("d6_rst_cnt",  {16'b0, bus.trap_cnt}, 32'd0);
        chk("d6_rst_pend", {28'b0, bus.irq_pending}, 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            step(4'($urandom), ($urandom_range(0, 15) == 0), 4'($urandom),
                 ($urandom_range(0, 2) == 0), 2'($urandom),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom,
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
